read_queue: RTL and testbench
=============================

READ_QUEUE -- requirements
Module: read_queue

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: width of the narrow upstream word from the leaf interface.
REQ-002 SHALL have parameter OUT_WIDTH, default 128: width of the wide word delivered to the user core.
REQ-003 SHALL have clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have ap_rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have din  input  IN_WIDTH: narrow data word from the leaf interface.
REQ-006 SHALL have vld_in  input  1: din valid.
REQ-007 SHALL have rdy_upward  output  1: block accepts din this cycle.
REQ-008 SHALL have dout  output  OUT_WIDTH: assembled wide word to the user core.
REQ-009 SHALL have vld_out  output  1: dout valid.
REQ-010 SHALL have rdy_downward  input  1: user core accepts dout this cycle.
REQ-011 SHALL have ap_start  input  1: enables acceptance of new input.

Function
REQ-012 SHALL require OUT_WIDTH to be an integer multiple of IN_WIDTH with RATIO = OUT_WIDTH/IN_WIDTH >= 2; any other setting is a configuration error.
REQ-013 SHALL define an input transfer as vld_in && rdy_upward on a rising edge, and an output transfer as vld_out && rdy_downward on a rising edge.
REQ-014 SHALL hold an assembly register, a slot counter cnt (0..RATIO-1, width clog2(RATIO)), an output register and an output-valid flag.
REQ-015 SHALL pack little-endian: the k-th word accepted after cnt=0 lands in bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
REQ-016 SHALL, on an input transfer with cnt < RATIO-1, write din into slot cnt and increment cnt.
REQ-017 SHALL, on an input transfer with cnt = RATIO-1, load the output register with the assembly contents plus din in the top slot, set vld_out, and wrap cnt to 0.
REQ-018 SHALL assert vld_out on the cycle after the final word's transfer (latency 1 cycle).
REQ-019 SHALL drive rdy_upward = ap_start && !(cnt = RATIO-1 && vld_out && !rdy_downward).
REQ-020 SHALL sustain one input transfer per cycle indefinitely while rdy_downward is held high.
REQ-021 SHALL, on an output transfer with no simultaneous completion, clear vld_out.
REQ-022 SHALL, on a simultaneous output transfer and completion, load the new word and keep vld_out high (no bubble).
REQ-023 SHALL hold dout and vld_out stable while vld_out && !rdy_downward.
REQ-024 SHALL continue draining a pending output word while ap_start is low, and retain a partial assembly and cnt across ap_start low.

Reset
REQ-025 SHALL, while ap_rst_n is low, asynchronously force cnt=0, vld_out=0, dout=0, assembly register=0.
REQ-026 SHALL, when ap_rst_n asserts mid-word or with vld_out high, discard the partial assembly and the pending word.
REQ-027 SHALL hold rdy_upward low while ap_rst_n is low.

Configuration
REQ-028 SHALL, when macro READ_QUEUE_FLUSH_EN is defined, add input port flush (1 bit); otherwise the port and its logic are absent.
REQ-029 SHALL, with READ_QUEUE_FLUSH_EN, on a cycle with flush high, cnt > 0 and rdy_upward-equivalent output slot free (!vld_out || rdy_downward), emit the partial word with unfilled slots zero, set vld_out, cnt to 0.
REQ-030 SHALL, with READ_QUEUE_FLUSH_EN, include a word accepted in the same cycle as flush in the flushed word; flush with cnt=0 and no input transfer, or with the output slot occupied, is ignored (no retry).
REQ-031 SHALL, with READ_QUEUE_FLUSH_EN, treat flush coincident with the final-slot input transfer as a normal completion.

Verification
REQ-032 SHALL verify: defaults, rdy_downward=1, din=0x11111111,0x22222222,0x33333333,0x44444444 on 4 consecutive cycles -> vld_out one cycle later, dout=0x44444444_33333333_22222222_11111111.
REQ-033 SHALL verify: 8 back-to-back words with rdy_downward=1 -> two output words, rdy_upward never low, vld_out high on two single cycles.
REQ-034 SHALL verify: rdy_downward=0 with one word pending, 3 more words accepted -> rdy_upward falls at cnt=3; raising rdy_downward -> 4th word accepted same cycle, next dout delivered without bubble.
REQ-035 SHALL verify: ap_start=0 after 2 words -> rdy_upward=0, cnt held at 2; ap_start=1 and 2 more words -> correct 128-bit word.
REQ-036 SHALL verify: ap_rst_n low for 1 cycle after 3 words -> vld_out=0, dout=0; next 4 words form a clean word with no stale data.
REQ-037 SHALL verify (READ_QUEUE_FLUSH_EN): 2 words 0xA,0xB then flush -> dout=0x00000000_00000000_0000000B_0000000A, cnt=0.

Source files
------------

// File: rtl/read_queue.sv
// Narrow-to-wide read queue: packs RATIO little-endian IN_WIDTH words into one OUT_WIDTH word.
// Optional partial-word flush is enabled by defining READ_QUEUE_FLUSH_EN.
module read_queue #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 128,
  localparam int RATIO = OUT_WIDTH / IN_WIDTH,
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 vld_in,
  output logic                 rdy_upward,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 vld_out,
  input  logic                 rdy_downward,
  input  logic                 ap_start,
`ifdef READ_QUEUE_FLUSH_EN
  input  logic                 flush,
`endif
  output logic [CW-1:0]        dbg_cnt
);

  if (((OUT_WIDTH % IN_WIDTH) != 0) || (RATIO < 2)) begin : g_cfg_error
    $error("read_queue: OUT_WIDTH must be an integer multiple (>= 2) of IN_WIDTH");
  end

  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid from the same side.
  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH-1:0] asm_q;
  logic [OUT_WIDTH-1:0] din_shifted;
  logic [OUT_WIDTH-1:0] asm_next;
  logic                 last;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 slot_free;
  logic                 complete;
  logic                 flush_fire;
  logic                 emit;

  assign last       = (cnt == LAST);
  assign rdy_upward = ap_rst_n && ap_start && !(last && vld_out && !rdy_downward);
  assign in_xfer    = vld_in && rdy_upward;
  assign out_xfer   = vld_out && rdy_downward;
  assign slot_free  = !vld_out || rdy_downward;
  assign complete   = in_xfer && last;
  assign dbg_cnt    = cnt;

  assign din_shifted = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, din} << (int'(cnt) * IN_WIDTH);

  // The assembly register is cleared on every emit, so unfilled slots are
  // always zero and the top slot is empty when the final word arrives.
  always_comb begin
    asm_next = asm_q;
    if (in_xfer) asm_next = asm_q | din_shifted;
  end

`ifdef READ_QUEUE_FLUSH_EN
  assign flush_fire = flush && !complete && slot_free && ((cnt != '0) || in_xfer);
`else
  assign flush_fire = 1'b0;
`endif

  assign emit = complete || flush_fire;

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt     <= '0;
      asm_q   <= '0;
      dout    <= '0;
      vld_out <= 1'b0;
    end else if (emit) begin
      dout    <= asm_next;
      vld_out <= 1'b1;
      cnt     <= '0;
      asm_q   <= '0;
    end else begin
      if (in_xfer) begin
        asm_q <= asm_next;
        cnt   <= cnt + CW'(1);
      end
      if (out_xfer) vld_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_queue.sv
// Self-checking bench for read_queue: directed scenarios followed by random traffic,
// all checked every cycle against a word-list reference model.
module tb_read_queue;
  localparam int IW    = 32;
  localparam int OW    = 128;
  localparam int RATIO = OW / IW;

  logic          clk = 1'b0;
  logic          ap_rst_n;
  logic [IW-1:0] din;
  logic          vld_in;
  logic          rdy_upward;
  logic [OW-1:0] dout;
  logic          vld_out;
  logic          rdy_downward;
  logic          ap_start;
  logic [1:0]    dbg_cnt;
`ifdef READ_QUEUE_FLUSH_EN
  logic          flush;
`endif

  int checks = 0;
  int errors = 0;
  int up_low;
  int vld_hi;

  // Reference model: words accepted so far for the word under assembly, and
  // completed words not yet taken by the consumer.
  logic [IW-1:0] part_q[$];
  logic [OW-1:0] exp_q[$];

  read_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk          (clk),
    .ap_rst_n     (ap_rst_n),
    .din          (din),
    .vld_in       (vld_in),
    .rdy_upward   (rdy_upward),
    .dout         (dout),
    .vld_out      (vld_out),
    .rdy_downward (rdy_downward),
    .ap_start     (ap_start),
`ifdef READ_QUEUE_FLUSH_EN
    .flush        (flush),
`endif
    .dbg_cnt      (dbg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack_words();
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < part_q.size(); i++) w[i*IW +: IW] = part_q[i];
    return w;
  endfunction

  // One clock: check outputs against the model mid-cycle, advance the model
  // by the transfers the coming edge will perform, then step past the edge.
  task automatic cyc();
    logic exp_rdy, in_x, out_x, fl;
    #2;
    if (!ap_rst_n) begin
      part_q.delete();
      exp_q.delete();
    end
    exp_rdy = ap_rst_n && ap_start &&
              !((part_q.size() == RATIO-1) && (exp_q.size() != 0) && !rdy_downward);
    chk("rdy_upward", OW'(rdy_upward), OW'(exp_rdy));
    chk("vld_out", OW'(vld_out), OW'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("dout", dout, exp_q[0]);
    else if (!ap_rst_n) chk("dout_rst", dout, '0);
    chk("cnt", OW'(dbg_cnt), OW'(part_q.size()));
    if (rdy_upward !== 1'b1) up_low++;
    if (vld_out === 1'b1) vld_hi++;
    in_x  = vld_in && exp_rdy;
    out_x = (exp_q.size() != 0) && rdy_downward;
    if (out_x) void'(exp_q.pop_front());
    if (in_x) part_q.push_back(din);
    fl = 1'b0;
`ifdef READ_QUEUE_FLUSH_EN
    fl = ap_rst_n && flush && (part_q.size() != 0) && (part_q.size() != RATIO) && (exp_q.size() == 0);
`endif
    if ((part_q.size() == RATIO) || fl) begin
      exp_q.push_back(pack_words());
      part_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ap_rst_n     = 1'b0;
    vld_in       = 1'b0;
    din          = '0;
    rdy_downward = 1'b1;
    ap_start     = 1'b1;
`ifdef READ_QUEUE_FLUSH_EN
    flush        = 1'b0;
`endif
    @(posedge clk);
    #1;
    cyc();
    cyc();
    ap_rst_n = 1'b1;

    // Four consecutive words form one wide word, visible one cycle later.
    for (int i = 0; i < 4; i++) begin
      vld_in = 1'b1;
      din    = IW'(32'h11111111 * (i + 1));
      cyc();
    end
    vld_in = 1'b0;
    chk("basic_vld", OW'(vld_out), OW'(1));
    chk("basic_dout", dout, 128'h44444444_33333333_22222222_11111111);
    cyc();

    // Eight back-to-back words: no stall, two single-cycle output pulses.
    up_low = 0;
    vld_hi = 0;
    for (int i = 0; i < 8; i++) begin
      vld_in = 1'b1;
      din    = IW'($urandom);
      cyc();
    end
    vld_in = 1'b0;
    cyc();
    chk("b2b_rdy_low_cycles", OW'(up_low), OW'(0));
    chk("b2b_vld_cycles", OW'(vld_hi), OW'(2));

    // Back-pressure: pending word plus three more, fourth must stall.
    rdy_downward = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vld_in = 1'b1;
      din    = IW'(32'hC0DE0000 + i);
      cyc();
    end
    din = 32'hC0DE0007;
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("stall_rdy", OW'(rdy_upward), OW'(0));
    chk("stall_dout_held", dout, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);
    rdy_downward = 1'b1;
    #1;
    chk("release_rdy", OW'(rdy_upward), OW'(1));
    cyc();
    vld_in = 1'b0;
    chk("no_bubble_vld", OW'(vld_out), OW'(1));
    chk("no_bubble_dout", dout, 128'hC0DE0007_C0DE0006_C0DE0005_C0DE0004);
    cyc();

    // ap_start low holds a partial assembly.
    for (int i = 0; i < 2; i++) begin
      vld_in = 1'b1;
      din    = IW'(32'hA0000001 + i);
      cyc();
    end
    ap_start = 1'b0;
    din      = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) cyc();
    chk("hold_cnt", OW'(dbg_cnt), OW'(2));
    ap_start = 1'b1;
    for (int i = 2; i < 4; i++) begin
      din = IW'(32'hA0000001 + i);
      cyc();
    end
    vld_in = 1'b0;
    chk("resume_dout", dout, 128'hA0000004_A0000003_A0000002_A0000001);
    cyc();

    // Reset mid-word discards the partial assembly.
    for (int i = 0; i < 3; i++) begin
      vld_in = 1'b1;
      din    = IW'(32'hEEEE0000 + i);
      cyc();
    end
    vld_in   = 1'b0;
    ap_rst_n = 1'b0;
    cyc();
    ap_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vld_in = 1'b1;
      din    = IW'(32'h55550000 + i);
      cyc();
    end
    vld_in = 1'b0;
    chk("post_reset_dout", dout, 128'h55550003_55550002_55550001_55550000);
    cyc();

`ifdef READ_QUEUE_FLUSH_EN
    // Flush emits a zero-padded partial word.
    vld_in = 1'b1;
    din    = 32'h0000000A;
    cyc();
    din    = 32'h0000000B;
    cyc();
    vld_in = 1'b0;
    flush  = 1'b1;
    cyc();
    flush  = 1'b0;
    chk("flush_dout", dout, 128'h00000000_00000000_0000000B_0000000A);
    chk("flush_cnt", OW'(dbg_cnt), OW'(0));
    cyc();
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      ap_rst_n     = ($urandom_range(0, 199) != 0);
      ap_start     = ($urandom_range(0, 9) != 0);
      vld_in       = ($urandom_range(0, 3) != 0);
      rdy_downward = ($urandom_range(0, 2) != 0);
      din          = IW'($urandom);
`ifdef READ_QUEUE_FLUSH_EN
      flush        = ($urandom_range(0, 7) == 0);
`endif
      cyc();
    end
    ap_rst_n     = 1'b1;
    vld_in       = 1'b0;
    rdy_downward = 1'b1;
`ifdef READ_QUEUE_FLUSH_EN
    flush        = 1'b0;
`endif
    for (int i = 0; i < 3; i++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
